// File: rtl/lfsr_12_6_4_pkg.sv
// lfsr_12_6_4_pkg: shared constants and state type for the 12/6/4 LFSR stream checker
package lfsr_12_6_4_pkg;
  localparam int LFSR_LEN = 12;
  localparam int TAP_A = 0;
  localparam int TAP_B = 3;
  localparam int TAP_C = 5;
  localparam int TAP_D = 11;
  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;
endpackage

// File: rtl/lfsr_12_6_4_predictor.sv
// lfsr_12_6_4_predictor: received-bit history and next-bit prediction for the 12/6/4 stream
module lfsr_12_6_4_predictor
  import lfsr_12_6_4_pkg::*;
(
  input  logic clock,
  input  logic reset_n,
  input  logic in,
  input  logic in_valid,
  output logic pred,
  output logic hist_zero
);
  logic [LFSR_LEN-1:0] h_q;
  logic [LFSR_LEN-1:0] h_d;
  // h_q[LFSR_LEN-1] holds the newest received bit
  always_comb h_d = in_valid ? {in, h_q[LFSR_LEN-1:1]} : h_q;
  always_ff @(posedge clock) begin
    if (!reset_n) h_q <= '0;
    else h_q <= h_d;
  end
  assign pred = h_q[TAP_A] ^ h_q[TAP_B] ^ h_q[TAP_C] ^ h_q[TAP_D];
  assign hist_zero = h_q == '0;
endmodule

// File: rtl/lfsr_12_6_4_checker.sv
// lfsr_12_6_4_checker: self-synchronising lock/error monitor for the 12/6/4 scrambled zero stream
module lfsr_12_6_4_checker
  import lfsr_12_6_4_pkg::*;
#(
  parameter int LOCK_CNT = 24,
  parameter int WINDOW = 64,
  parameter int LOSS_THRESH = 8,
  parameter int ERR_W = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in,
  input  logic             in_valid,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             bit_err,
  output logic [ERR_W-1:0] err_count
);
  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int WW = $clog2(WINDOW + 1);
  localparam int EW = $clog2(LOSS_THRESH + 1);
  state_t state_q;
  state_t state_d;
  logic [3:0] fill_q;
  logic [3:0] fill_d;
  logic [MW-1:0] match_q;
  logic [MW-1:0] match_d;
  logic [WW-1:0] win_cnt_q;
  logic [WW-1:0] win_cnt_d;
  logic [EW-1:0] win_err_q;
  logic [EW-1:0] win_err_d;
  logic [EW-1:0] win_err_inc;
  logic locked_q;
  logic locked_d;
  logic bit_err_q;
  logic bit_err_d;
  logic [ERR_W-1:0] err_count_q;
  logic [ERR_W-1:0] err_count_d;
  logic pred;
  logic hist_zero;
  logic mismatch;
  lfsr_12_6_4_predictor u_pred (
    .clock    (clock),
    .reset_n  (reset_n),
    .in       (in),
    .in_valid (in_valid),
    .pred     (pred),
    .hist_zero(hist_zero)
  );
  // an all-zero history can never occur in a live stream, so treat it as an error
  assign mismatch = (in != pred) | hist_zero;
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= HUNT;
      fill_q      <= '0;
      match_q     <= '0;
      win_cnt_q   <= '0;
      win_err_q   <= '0;
      locked_q    <= 1'b0;
      bit_err_q   <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      fill_q      <= fill_d;
      match_q     <= match_d;
      win_cnt_q   <= win_cnt_d;
      win_err_q   <= win_err_d;
      locked_q    <= locked_d;
      bit_err_q   <= bit_err_d;
      err_count_q <= err_count_d;
    end
  end
  always_comb begin
    state_d = state_q;
    fill_d = fill_q;
    match_d = match_q;
    win_cnt_d = win_cnt_q;
    win_err_d = win_err_q;
    win_err_inc = win_err_q + EW'(mismatch);
    if (in_valid) begin
      case (state_q)
        HUNT: begin
          if (fill_q == 4'(LFSR_LEN - 1)) begin
            state_d = VERIFY;
            match_d = '0;
          end else fill_d = fill_q + 4'd1;
        end
        VERIFY: begin
          if (mismatch) match_d = '0;
          else if (match_q == MW'(LOCK_CNT - 1)) begin
            state_d = LOCKED;
            win_cnt_d = '0;
            win_err_d = '0;
          end else match_d = match_q + MW'(1);
        end
        LOCKED: begin
          if (win_err_inc == EW'(LOSS_THRESH)) begin
            state_d = HUNT;
            fill_d = '0;
          end else if (win_cnt_q == WW'(WINDOW - 1)) begin
            win_cnt_d = '0;
            win_err_d = '0;
          end else begin
            win_cnt_d = win_cnt_q + WW'(1);
            win_err_d = win_err_inc;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end
  always_comb begin
    bit_err_d = in_valid && state_q == LOCKED && mismatch;
    locked_d = state_d == LOCKED;
    err_count_d = clr_cnt ? '0 :
                  (bit_err_d && err_count_q != '1) ? err_count_q + ERR_W'(1) : err_count_q;
  end
  assign locked = locked_q;
  assign bit_err = bit_err_q;
  assign err_count = err_count_q;
endmodule
